// File: rtl/oq_pkt_writer_pkg.sv
// Shared definitions for the output-queue packet writer.
//   wr_state_e    : writer FSM states
//   IOQ_STAGE_NUM : control-byte value that marks a module-header word
//   log2          : ceiling log2 for parameter-derived widths
package oq_pkt_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_MOVE,
    ST_DROP,
    ST_DONE
  } wr_state_e;

  localparam logic [7:0] IOQ_STAGE_NUM = 8'hff;

  function automatic int unsigned log2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/oq_pkt_writer_if.sv
// Bus bundle between the packet writer and its surroundings: parser FIFO,
// input data FIFO, queue-manager status/report and SRAM write port.
//   master : the packet writer
//   slave  : the environment (parser, FIFO, queue manager, SRAM arbiter)
interface oq_pkt_writer_if #(
  parameter int unsigned DATA_WIDTH         = 64,
  parameter int unsigned NUM_OUTPUT_QUEUES  = 8,
  parameter int unsigned PKT_BYTE_CNT_WIDTH = 11,
  parameter int unsigned PKT_WORD_CNT_WIDTH = 8,
  parameter int unsigned SRAM_ADDR_WIDTH    = 19
);
  localparam int unsigned CTRL_WIDTH   = DATA_WIDTH / 8;
  localparam int unsigned NUM_OQ_WIDTH = oq_pkt_writer_pkg::log2(NUM_OUTPUT_QUEUES);

  // parser FIFO
  logic                            dst_oq_avail;
  logic [NUM_OQ_WIDTH-1:0]         parsed_dst_oq;
  logic [PKT_BYTE_CNT_WIDTH-1:0]   parsed_pkt_byte_len;
  logic [PKT_WORD_CNT_WIDTH-1:0]   parsed_pkt_word_len;
  logic                            rd_dst_oq;
  // input FIFO
  logic [DATA_WIDTH-1:0]           in_fifo_data;
  logic [CTRL_WIDTH-1:0]           in_fifo_ctrl;
  logic                            in_fifo_empty;
  logic                            in_fifo_rd_en;
  // queue-manager status
  logic [NUM_OQ_WIDTH-1:0]         oq_sel;
  logic [SRAM_ADDR_WIDTH-1:0]      oq_wr_addr;
  logic [SRAM_ADDR_WIDTH-1:0]      oq_addr_lo;
  logic [SRAM_ADDR_WIDTH-1:0]      oq_addr_hi;
  logic [SRAM_ADDR_WIDTH-1:0]      oq_words_free;
  // SRAM write port
  logic                            sram_wr_req;
  logic [SRAM_ADDR_WIDTH-1:0]      sram_wr_addr;
  logic [DATA_WIDTH+CTRL_WIDTH-1:0] sram_wr_data;
  logic                            sram_wr_ack;
  // queue-manager report
  logic                            pkt_stored;
  logic [NUM_OQ_WIDTH-1:0]         pkt_stored_oq;
  logic [SRAM_ADDR_WIDTH-1:0]      pkt_stored_next_addr;
  logic [PKT_WORD_CNT_WIDTH:0]     pkt_stored_words;
  logic [PKT_BYTE_CNT_WIDTH-1:0]   pkt_stored_bytes;
  logic                            pkt_dropped;
  logic                            pkt_len_err;

  modport master (
    input  dst_oq_avail, parsed_dst_oq, parsed_pkt_byte_len, parsed_pkt_word_len,
    output rd_dst_oq,
    input  in_fifo_data, in_fifo_ctrl, in_fifo_empty,
    output in_fifo_rd_en,
    output oq_sel,
    input  oq_wr_addr, oq_addr_lo, oq_addr_hi, oq_words_free,
    output sram_wr_req, sram_wr_addr, sram_wr_data,
    input  sram_wr_ack,
    output pkt_stored, pkt_stored_oq, pkt_stored_next_addr, pkt_stored_words,
    output pkt_stored_bytes, pkt_dropped, pkt_len_err
  );

  modport slave (
    output dst_oq_avail, parsed_dst_oq, parsed_pkt_byte_len, parsed_pkt_word_len,
    input  rd_dst_oq,
    output in_fifo_data, in_fifo_ctrl, in_fifo_empty,
    input  in_fifo_rd_en,
    input  oq_sel,
    output oq_wr_addr, oq_addr_lo, oq_addr_hi, oq_words_free,
    input  sram_wr_req, sram_wr_addr, sram_wr_data,
    output sram_wr_ack,
    input  pkt_stored, pkt_stored_oq, pkt_stored_next_addr, pkt_stored_words,
    input  pkt_stored_bytes, pkt_dropped, pkt_len_err
  );

endinterface

// File: rtl/oq_pkt_writer_eop_tracker.sv
// End-of-packet detector for the word stream popped from the input FIFO.
// A word is EOP when its control byte is non-zero and at least one
// control==0 (payload) word has been popped since the last clear/EOP.
//   clk, reset : clock, synchronous active-high reset
//   clear      : start of a new packet
//   pop        : a word is being popped this cycle
//   ctrl       : control byte of the popped word
//   eop        : combinational, popped word is the EOP word
module oq_pkt_writer_eop_tracker #(
  parameter int unsigned CTRL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  pop,
  input  logic [CTRL_WIDTH-1:0] ctrl,
  output logic                  eop
);

  logic seen_data_q, seen_data_d;

  always_comb begin
    eop         = pop && (ctrl != '0) && seen_data_q;
    seen_data_d = seen_data_q;
    if (clear || eop)             seen_data_d = 1'b0;
    else if (pop && ctrl == '0)   seen_data_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) seen_data_q <= 1'b0;
    else       seen_data_q <= seen_data_d;
  end

endmodule

// File: rtl/oq_pkt_writer.sv
// Output-queue packet writer. Pops {dst_oq, byte_len, word_len} from the
// parser FIFO, checks free space in that queue, then copies the packet's
// words from the input FIFO into the queue's circular SRAM region (or
// discards them when the packet does not fit) and reports the result.
//   clk, reset : clock, synchronous active-high reset
//   bus        : oq_pkt_writer_if.master (parser FIFO, input FIFO,
//                queue-manager status/report, SRAM write port)
//   drop_cnt   : only with OQ_PKT_WRITER_DROP_CNT_EN defined; per-queue
//                32-bit saturating drop counters, queue i at [32*i +: 32]
module oq_pkt_writer
  import oq_pkt_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 64,
  parameter int unsigned NUM_OUTPUT_QUEUES  = 8,
  parameter int unsigned PKT_BYTE_CNT_WIDTH = 11,
  parameter int unsigned PKT_WORD_CNT_WIDTH = 8,
  parameter int unsigned SRAM_ADDR_WIDTH    = 19,
  parameter int unsigned HDR_WORDS          = 1
) (
  input  logic            clk,
  input  logic            reset,
  oq_pkt_writer_if.master bus
`ifdef OQ_PKT_WRITER_DROP_CNT_EN
  ,
  output logic [NUM_OUTPUT_QUEUES*32-1:0] drop_cnt
`endif
);

  localparam int unsigned CTRL_WIDTH   = DATA_WIDTH / 8;
  localparam int unsigned NUM_OQ_WIDTH = log2(NUM_OUTPUT_QUEUES);
  localparam int unsigned CW           = PKT_WORD_CNT_WIDTH + 1;
  localparam logic [CW-1:0] HDR_W      = CW'(HDR_WORDS);
  localparam logic [CW-1:0] ONE_W      = CW'(1);

  wr_state_e                         state_q, state_d;
  logic [NUM_OQ_WIDTH-1:0]           oq_q, oq_d;
  logic [PKT_BYTE_CNT_WIDTH-1:0]     bytes_q, bytes_d;
  logic [CW-1:0]                     need_q, need_d;
  logic [CW-1:0]                     cnt_q, cnt_d;        // words acked
  logic [CW-1:0]                     popcnt_q, popcnt_d;  // words accepted for writing
  logic [SRAM_ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic                              req_q, req_d;
  logic [DATA_WIDTH+CTRL_WIDTH-1:0]  data_q, data_d;
  logic                              eop_popped_q, eop_popped_d;
  logic                              rd_dst_oq_q, rd_dst_oq_d;
  logic                              stored_q, stored_d;
  logic                              dropped_q, dropped_d;
  logic                              len_err_q, len_err_d;

  logic pop;
  logic trk_clear;
  logic eop;

  oq_pkt_writer_eop_tracker #(.CTRL_WIDTH(CTRL_WIDTH)) u_eop (
    .clk   (clk),
    .reset (reset),
    .clear (trk_clear),
    .pop   (bus.in_fifo_rd_en),
    .ctrl  (bus.in_fifo_ctrl),
    .eop   (eop)
  );

  always_comb begin
    state_d      = state_q;
    oq_d         = oq_q;
    bytes_d      = bytes_q;
    need_d       = need_q;
    cnt_d        = cnt_q;
    popcnt_d     = popcnt_q;
    addr_d       = addr_q;
    req_d        = req_q;
    data_d       = data_q;
    eop_popped_d = eop_popped_q;
    rd_dst_oq_d  = 1'b0;
    stored_d     = 1'b0;
    dropped_d    = 1'b0;
    len_err_d    = 1'b0;
    pop          = 1'b0;
    trk_clear    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.dst_oq_avail) begin
          rd_dst_oq_d = 1'b1;
          oq_d        = bus.parsed_dst_oq;
          bytes_d     = bus.parsed_pkt_byte_len;
          need_d      = {1'b0, bus.parsed_pkt_word_len} + HDR_W;
          trk_clear   = 1'b1;
          state_d     = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (bus.oq_words_free >= SRAM_ADDR_WIDTH'(need_q)) begin
          addr_d       = bus.oq_wr_addr;
          cnt_d        = '0;
          popcnt_d     = '0;
          eop_popped_d = 1'b0;
          state_d      = ST_MOVE;
        end else begin
          state_d = ST_DROP;
        end
      end

      ST_MOVE: begin
        if (req_q && bus.sram_wr_ack) begin
          req_d  = 1'b0;
          addr_d = (addr_q == bus.oq_addr_hi) ? bus.oq_addr_lo
                                              : addr_q + SRAM_ADDR_WIDTH'(1);
          cnt_d  = cnt_q + ONE_W;
        end
        // A word can be popped in the same cycle the previous one is acked,
        // which keeps a same-cycle-ack SRAM at one word per clock.
        if (!eop_popped_q && !bus.in_fifo_empty && (!req_q || bus.sram_wr_ack)) begin
          pop = 1'b1;
          if (popcnt_q < need_q) begin
            req_d    = 1'b1;
            data_d   = {bus.in_fifo_ctrl, bus.in_fifo_data};
            popcnt_d = popcnt_q + ONE_W;
          end
          if (eop) begin
            eop_popped_d = 1'b1;
            if (popcnt_q >= need_q) len_err_d = 1'b1;
          end
        end
        if (eop_popped_d && !req_d) begin
          stored_d = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_DROP: begin
        if (!bus.in_fifo_empty) begin
          pop = 1'b1;
          if (eop) begin
            dropped_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      oq_q         <= '0;
      bytes_q      <= '0;
      need_q       <= '0;
      cnt_q        <= '0;
      popcnt_q     <= '0;
      addr_q       <= '0;
      req_q        <= 1'b0;
      data_q       <= '0;
      eop_popped_q <= 1'b0;
      rd_dst_oq_q  <= 1'b0;
      stored_q     <= 1'b0;
      dropped_q    <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      oq_q         <= oq_d;
      bytes_q      <= bytes_d;
      need_q       <= need_d;
      cnt_q        <= cnt_d;
      popcnt_q     <= popcnt_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      data_q       <= data_d;
      eop_popped_q <= eop_popped_d;
      rd_dst_oq_q  <= rd_dst_oq_d;
      stored_q     <= stored_d;
      dropped_q    <= dropped_d;
      len_err_q    <= len_err_d;
    end
  end

  assign bus.rd_dst_oq            = rd_dst_oq_q;
  assign bus.in_fifo_rd_en        = pop && !reset;
  assign bus.oq_sel               = oq_q;
  assign bus.sram_wr_req          = req_q;
  assign bus.sram_wr_addr         = addr_q;
  assign bus.sram_wr_data         = data_q;
  assign bus.pkt_stored           = stored_q;
  assign bus.pkt_stored_oq        = oq_q;
  assign bus.pkt_stored_next_addr = addr_q;
  assign bus.pkt_stored_words     = cnt_q;
  assign bus.pkt_stored_bytes     = bytes_q;
  assign bus.pkt_dropped          = dropped_q;
  assign bus.pkt_len_err          = len_err_q;

`ifdef OQ_PKT_WRITER_DROP_CNT_EN
  logic [31:0] drop_cnt_q [NUM_OUTPUT_QUEUES];
  logic [31:0] drop_cnt_d [NUM_OUTPUT_QUEUES];

  // oq_q still holds the dropped packet's queue while the pulse is high.
  always_comb begin
    for (int unsigned i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
      drop_cnt_d[i] = drop_cnt_q[i];
      if (dropped_q && oq_q == NUM_OQ_WIDTH'(i) && drop_cnt_q[i] != '1)
        drop_cnt_d[i] = drop_cnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
      if (reset) drop_cnt_q[i] <= '0;
      else       drop_cnt_q[i] <= drop_cnt_d[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_OUTPUT_QUEUES; i++)
      drop_cnt[i*32 +: 32] = drop_cnt_q[i];
  end
`endif

endmodule
